// File: rtl/muldiv_pkg.sv
// Shared constants and types for the iterative MULTU/DIVU unit.
// Optional DIVU support is enabled by defining MULDIV_DIVU_EN.
package muldiv_pkg;

    localparam int DATA_W   = 32;
    localparam int ITER_CNT = 32;

    localparam logic [1:0] MD_MULTU = 2'b00;
    localparam logic [1:0] MD_DIVU  = 2'b01;

    // MIPS SPECIAL funct codes for the instructions this unit serves
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1b;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } md_state_t;

    function automatic logic is_last_iter(input logic [5:0] cnt);
        return cnt == 6'(ITER_CNT - 1);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the 64-bit shift/accumulate datapath.
// Restoring-division step exists only when MULDIV_DIVU_EN is defined.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [63:0] acc,
    input  logic [31:0] opnd,
    output logic [63:0] acc_nxt
);

    // Multiply: {HI,LO} holds {partial sum, remaining multiplier}; add then shift right.
    logic [32:0] mul_sum;
    logic [63:0] mul_nxt;

    assign mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    assign mul_nxt = {mul_sum, acc[31:1]};

`ifdef MULDIV_DIVU_EN
    // Divide: {R,Q} shifted left; the shifted remainder needs 33 bits before the compare.
    logic [32:0] rem_sh;
    logic [31:0] rem_sub;
    logic        fits;

    assign rem_sh  = acc[63:31];
    assign fits    = rem_sh >= {1'b0, opnd};
    assign rem_sub = rem_sh[31:0] - opnd;
    assign acc_nxt = (op == MD_DIVU) ?
                     {(fits ? rem_sub : rem_sh[31:0]), acc[30:0], fits} : mul_nxt;
`else
    logic unused_op;
    assign unused_op = ^op;
    assign acc_nxt   = mul_nxt;
`endif

endmodule

// File: rtl/muldiv_ctrl.sv
// MULTU/DIVU controller: FSM, iteration counter, HI/LO registers and stall.
// Defining MULDIV_DIVU_EN adds op=01 DIVU; otherwise op=01 is reserved.
module muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] srca,
    input  logic [31:0] srcb,
    input  logic        rd_req,
    input  logic        rd_sel,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic        done,
    output logic        stall
);

    md_state_t   state;
    md_state_t   state_nxt;
    logic [5:0]  cnt;
    logic [1:0]  op_q;
    logic [31:0] opnd;
    logic [63:0] acc;
    logic [63:0] acc_nxt;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        op_ok;
    logic        accept;
    logic        last;

`ifdef MULDIV_DIVU_EN
    assign op_ok = (op == MD_MULTU) || (op == MD_DIVU);
`else
    assign op_ok = (op == MD_MULTU);
`endif

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                accept = start & op_ok;
                if (accept) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                last = is_last_iter(cnt);
                if (last) state_nxt = DONE;
            end
            DONE: begin
                done   = 1'b1;
                accept = start & op_ok;
                state_nxt = accept ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign stall   = busy & (start | rd_req);
    assign rd_data = rd_sel ? hi : lo;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counter and architectural HI/LO; HI/LO change only when an operation completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= 6'd0;
            hi  <= 32'd0;
            lo  <= 32'd0;
        end else begin
            if (accept)
                cnt <= 6'd0;
            else if (busy)
                cnt <= cnt + 6'd1;
            if (last) begin
                hi <= acc_nxt[63:32];
                lo <= acc_nxt[31:0];
            end
        end
    end

    // Working datapath registers carry no reset; they are always loaded on accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q <= op;
            if (op == MD_MULTU) begin
                acc  <= {32'd0, srcb};
                opnd <= srca;
            end else begin
                acc  <= {32'd0, srca};
                opnd <= srcb;
            end
        end else if (busy) begin
            acc <= acc_nxt;
        end
    end

    muldiv_step u_step (
        .op      (op_q),
        .acc     (acc),
        .opnd    (opnd),
        .acc_nxt (acc_nxt)
    );

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port: start  in  1  decoder request to begin a MULTU/DIVU operation.
REQ-004 SHALL have port: op  in  2  operation: 00 MULTU, 01 DIVU, 10/11 reserved.
REQ-005 SHALL have port: srca  in  32  rs operand (multiplicand/dividend).
REQ-006 SHALL have port: srcb  in  32  rt operand (multiplier/divisor).
REQ-007 SHALL have port: rd_req  in  1  MFHI/MFLO read request.
REQ-008 SHALL have port: rd_sel  in  1  0 = LO, 1 = HI.
REQ-009 SHALL have port: rd_data  out  32  selected HI/LO value, combinational from registers.
REQ-010 SHALL have port: busy  out  1  operation in progress.
REQ-011 SHALL have port: done  out  1  one-cycle pulse, HI/LO freshly written.
REQ-012 SHALL have port: stall  out  1  freeze request to the fetch/PC path.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
- IDLE: start=1 with a valid op -> capture srca, srcb, op; clear 6-bit counter; go to RUN.
- RUN: one iteration per cycle; after the 32nd RUN cycle -> write HI/LO, go to DONE.
- DONE: done=1 for one cycle; start with a valid op is accepted exactly as in IDLE; otherwise -> IDLE.
REQ-014 SHALL give fixed latency: start sampled at edge t -> RUN during cycles t+1..t+32 -> done=1 and new HI/LO visible in cycle t+33.
REQ-015 SHALL compute MULTU as iterative unsigned shift-add, HI = product[63:32], LO = product[31:0], with no truncation.
REQ-016 SHALL hold busy=1 in RUN only, and busy=0 in IDLE and DONE.
REQ-017 SHALL drive stall = busy & (start | rd_req).
REQ-018 SHALL ignore start while busy: operands are not recaptured and the running operation is unaffected. The stalled instruction re-presents start once stall drops.
REQ-019 SHALL keep HI/LO unchanged until the operation completes. Reads in IDLE or DONE return the current register values with no stall.
REQ-020 SHALL ignore start with a reserved op: no state change and no stall.
REQ-021 SHALL ignore rd_req and rd_sel for all state changes; they affect only stall and rd_data.

Reset
REQ-022 SHALL on reset=1, in any state including mid-RUN, go to IDLE at the next edge, with HI=0, LO=0, counter=0, busy=0, done=0, stall=0.
REQ-023 SHALL give reset priority over a simultaneous start.

Configuration
REQ-024 SHALL, with MULDIV_DIVU_EN defined, support op=01 DIVU by restoring division over the same 32 RUN cycles: LO = quotient, HI = remainder.
REQ-025 SHALL, for DIVU with divisor 0, produce LO=0xFFFFFFFF and HI=dividend, with no exception and the same latency.
REQ-026 SHALL, with MULDIV_DIVU_EN undefined, treat op=01 as reserved (REQ-020) and synthesize no divider logic.

Structure
REQ-027 SHALL place the op encodings (MD_MULTU, MD_DIVU), the FSM state encoding, the iteration count (32), and the MULTU/DIVU/MFHI/MFLO funct constants in the shared package muldiv_pkg.
REQ-028 SHALL split the 64-bit shift/accumulate datapath (one iteration step, op-selected) into sub-module muldiv_step. The FSM, counter and HI/LO registers stay in muldiv_ctrl.

Verification
REQ-029 SHALL cover: start MULTU 0xFFFFFFFF*0xFFFFFFFF at t -> busy=1 during t+1..t+32, done=1 at t+33, HI=0xFFFFFFFE, LO=0x00000001.
REQ-030 SHALL cover: MULTU 3*5, rd_req=1 with rd_sel=0 from RUN cycle 5 -> stall=1 until DONE; rd_data=15 in DONE.
REQ-031 SHALL cover: MULTU in progress, reset=1 at RUN cycle 10 -> next cycle busy=0, HI=0, LO=0; a later read returns 0.
REQ-032 SHALL cover: MULTU 2*2, then start MULTU 7*6 in its DONE cycle -> second operation accepted with no IDLE gap, LO=42, HI=0.
REQ-033 SHALL cover: start while busy with different operands -> stall=1, result reflects only the original operands.
REQ-034 SHALL cover, with MULDIV_DIVU_EN defined: DIVU 100/7 -> LO=14, HI=2; DIVU 100/0 -> LO=0xFFFFFFFF, HI=100. With the macro undefined, op=01 -> busy stays 0.
